per2axi_core_arbiter: RTL and testbench

//  Shares one per2axi bridge slave port among NB_CORES peripheral-interconnect requesters.

---
 rtl/per2axi_core_arbiter_pkg.sv | 27 ++
 rtl/per2axi_core_arbiter_if.sv | 46 ++++
 rtl/per2axi_core_arbiter_rr.sv | 17 +
 rtl/per2axi_core_arbiter.sv | 126 ++++++++++++
 tb/tb_per2axi_core_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/per2axi_core_arbiter_pkg.sv
// Shared types and the round-robin search used by the per2axi core arbiter.
// The typedefs describe the default configuration; the picker works for any core count up to MAX_CORES.
package per2axi_arb_pkg;

  localparam int unsigned MAX_CORES     = 32;
  localparam int unsigned MAX_IDX_W     = $clog2(MAX_CORES);
  localparam int unsigned NB_CORES_DEF  = 4;
  localparam int unsigned MAX_OUTST_DEF = 2;

  typedef logic [$clog2(NB_CORES_DEF)-1:0]    core_idx_t;
  typedef logic [$clog2(MAX_OUTST_DEF+1)-1:0] cnt_t;

  // First set bit of req at or after ptr, wrapping at n; returns ptr when req is empty.
  // Scans from the farthest offset down so the nearest candidate is written last.
  function automatic int unsigned rr_pick(input logic [MAX_CORES-1:0] req,
                                          input int unsigned          ptr,
                                          input int unsigned          n);
    int unsigned cand;
    rr_pick = ptr;
    for (int unsigned off = MAX_CORES; off > 0; off--) begin
      cand = ptr + off - 1;
      if (cand >= n) cand = cand - n;
      if (off <= n && req[cand[MAX_IDX_W-1:0]]) rr_pick = cand;
    end
  endfunction

endpackage

// File: rtl/per2axi_core_arbiter_if.sv
// Request/response bundle between the peripheral-interconnect cores, the arbiter and per2axi.
// slave is the arbiter's view; master is the surrounding cores plus per2axi.
interface per2axi_core_arbiter_if #(
   parameter int unsigned NB_CORES       = 4,
   parameter int unsigned PER_ADDR_WIDTH = 32,
   parameter int unsigned PER_DATA_WIDTH = 32,
   parameter int unsigned PER_ID_WIDTH   = 5
) ();

   logic [NB_CORES-1:0]                    core_req_i;
   logic [NB_CORES*PER_ADDR_WIDTH-1:0]     core_add_i;
   logic [NB_CORES-1:0]                    core_wen_i;
   logic [NB_CORES*PER_DATA_WIDTH-1:0]     core_wdata_i;
   logic [NB_CORES*PER_DATA_WIDTH/8-1:0]   core_be_i;
   logic [NB_CORES-1:0]                    core_gnt_o;
   logic [NB_CORES-1:0]                    core_r_valid_o;
   logic                                   core_r_opc_o;
   logic [PER_DATA_WIDTH-1:0]              core_r_rdata_o;

   logic                                   per_req_o;
   logic [PER_ADDR_WIDTH-1:0]              per_add_o;
   logic                                   per_wen_o;
   logic [PER_DATA_WIDTH-1:0]              per_wdata_o;
   logic [PER_DATA_WIDTH/8-1:0]            per_be_o;
   logic [PER_ID_WIDTH-1:0]                per_id_o;
   logic                                   per_gnt_i;
   logic                                   per_r_valid_i;
   logic                                   per_r_opc_i;
   logic [PER_ID_WIDTH-1:0]                per_r_id_i;
   logic [PER_DATA_WIDTH-1:0]              per_r_rdata_i;

   modport slave (
      input  core_req_i, core_add_i, core_wen_i, core_wdata_i, core_be_i,
             per_gnt_i, per_r_valid_i, per_r_opc_i, per_r_id_i, per_r_rdata_i,
      output core_gnt_o, core_r_valid_o, core_r_opc_o, core_r_rdata_o,
             per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_id_o
   );

   modport master (
      output core_req_i, core_add_i, core_wen_i, core_wdata_i, core_be_i,
             per_gnt_i, per_r_valid_i, per_r_opc_i, per_r_id_i, per_r_rdata_i,
      input  core_gnt_o, core_r_valid_o, core_r_opc_o, core_r_rdata_o,
             per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_id_o
   );

endinterface

// File: rtl/per2axi_core_arbiter_rr.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping at N.
module per2axi_arb_rr
   import per2axi_arb_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          valid
);

   assign idx   = IW'(rr_pick(MAX_CORES'(req), 32'(ptr), N));
   assign valid = |req;

endmodule

// File: rtl/per2axi_core_arbiter.sv
// Shares one per2axi slave port among NB_CORES requesters: round-robin with a per-core
// outstanding cap, a selection lock held until grant, id tagging and response routing by r_id.
module per2axi_core_arbiter
   import per2axi_arb_pkg::*;
#(
   parameter int unsigned NB_CORES       = 4,
   parameter int unsigned PER_ADDR_WIDTH = 32,
   parameter int unsigned PER_DATA_WIDTH = 32,
   parameter int unsigned PER_ID_WIDTH   = 5,
   parameter int unsigned MAX_OUTST      = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   per2axi_core_arbiter_if.slave bus,
   output logic                 busy_o,
   output logic                 err_o
);

   localparam int unsigned IW = $clog2(NB_CORES);
   localparam int unsigned CW = $clog2(MAX_OUTST + 1);
   localparam int unsigned BW = PER_DATA_WIDTH / 8;

   logic [CW-1:0]       cnt_q [NB_CORES];
   logic [IW-1:0]       rr_q;
   logic [IW-1:0]       lidx_q;
   logic                lock_q;
   logic                err_q;

   logic [NB_CORES-1:0] eligible;
   logic [NB_CORES-1:0] rsp_hit;
   logic [IW-1:0]       pick_idx;
   logic [IW-1:0]       winner;
   logic                pick_valid;
   logic                req_any;
   logic                hs;
   logic                rsp_bad;
   logic                cnt_nz;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      eligible = '0;
      cnt_nz   = 1'b0;
      for (int i = 0; i < NB_CORES; i++) begin
         eligible[i] = bus.core_req_i[i] && (cnt_q[i] < CW'(MAX_OUTST));
         cnt_nz      = cnt_nz | (cnt_q[i] != '0);
      end
   end

   per2axi_arb_rr #(.N(NB_CORES)) u_rr (
      .req   (eligible),
      .ptr   (rr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // A locked core was eligible when it locked, so it bypasses the picker until granted.
   assign winner  = lock_q ? lidx_q : pick_idx;
   assign req_any = !rst_i && (lock_q || pick_valid);
   assign hs      = req_any && bus.per_gnt_i;

   always_comb begin
      bus.core_gnt_o  = '0;
      bus.per_add_o   = '0;
      bus.per_wen_o   = 1'b0;
      bus.per_wdata_o = '0;
      bus.per_be_o    = '0;
      for (int i = 0; i < NB_CORES; i++) begin
         if (req_any && winner == IW'(i)) begin
            bus.core_gnt_o[i] = bus.per_gnt_i;
            bus.per_add_o     = bus.core_add_i[i*PER_ADDR_WIDTH +: PER_ADDR_WIDTH];
            bus.per_wen_o     = bus.core_wen_i[i];
            bus.per_wdata_o   = bus.core_wdata_i[i*PER_DATA_WIDTH +: PER_DATA_WIDTH];
            bus.per_be_o      = bus.core_be_i[i*BW +: BW];
         end
      end
   end

   assign bus.per_req_o = req_any;
   assign bus.per_id_o  = req_any ? PER_ID_WIDTH'(winner) : '0;

   // A response is only routed if its core actually has a transaction in flight.
   always_comb begin
      rsp_hit = '0;
      for (int i = 0; i < NB_CORES; i++) begin
         rsp_hit[i] = bus.per_r_valid_i && (bus.per_r_id_i == PER_ID_WIDTH'(i)) && (cnt_q[i] != '0);
      end
   end

   assign rsp_bad            = bus.per_r_valid_i && !(|rsp_hit);
   assign bus.core_r_valid_o = rst_i ? '0 : rsp_hit;
   assign bus.core_r_opc_o   = !rst_i && bus.per_r_opc_i;
   assign bus.core_r_rdata_o = rst_i ? '0 : bus.per_r_rdata_i;

   assign busy_o = !rst_i && (cnt_nz || req_any);
   assign err_o  = !rst_i && err_q;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NB_CORES; i++) cnt_q[i] <= '0;
         rr_q   <= '0;
         lidx_q <= '0;
         lock_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NB_CORES; i++) begin
            if ((hs && winner == IW'(i)) && !rsp_hit[i]) begin
               cnt_q[i] <= cnt_q[i] + CW'(1);
            end else if (!(hs && winner == IW'(i)) && rsp_hit[i]) begin
               cnt_q[i] <= cnt_q[i] - CW'(1);
            end
         end

         if (hs) begin
            lock_q <= 1'b0;
            rr_q   <= (winner == IW'(NB_CORES - 1)) ? '0 : winner + IW'(1);
         end else if (req_any) begin
            lock_q <= 1'b1;
            lidx_q <= winner;
         end

         if (rsp_bad) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_per2axi_core_arbiter.sv
// Self-checking bench for per2axi_core_arbiter: table-driven round-robin sweep plus hand-written
// lock, cap, same-cycle, error and reset sequences; a tag queue tracks in-flight transactions.
module tb_per2axi_core_arbiter;
   import per2axi_arb_pkg::*;

   localparam int unsigned NB  = 4;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned IDW = 5;
   localparam int unsigned MO  = 2;
   localparam int unsigned BW  = DW / 8;

   typedef struct {
      logic [NB-1:0] req;
      logic          gnt;
      logic          exp_req;
      logic [NB-1:0] exp_gnt;
      core_idx_t     exp_id;
   } vec_t;

   logic      clk = 1'b0;
   logic      rst;
   logic      busy;
   logic      err;
   int        checks   = 0;
   int        failures = 0;
   core_idx_t sb_q[$];
   vec_t      tbl[9];
   logic [NB-1:0] wen_pat;

   per2axi_core_arbiter_if #(.NB_CORES(NB), .PER_ADDR_WIDTH(AW), .PER_DATA_WIDTH(DW),
                             .PER_ID_WIDTH(IDW)) bus ();

   per2axi_core_arbiter #(.NB_CORES(NB), .PER_ADDR_WIDTH(AW), .PER_DATA_WIDTH(DW),
                          .PER_ID_WIDTH(IDW), .MAX_OUTST(MO)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bus),
      .busy_o (busy),
      .err_o  (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [AW-1:0] addr_of(int i);
      return 32'h4000_0000 + 32'(i) * 32'h100;
   endfunction
   function automatic logic [DW-1:0] wdata_of(int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction
   function automatic logic [BW-1:0] be_of(int i);
      return BW'(i + 1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.core_req_i    = '0;
      bus.per_gnt_i     = 1'b0;
      bus.per_r_valid_i = 1'b0;
   endtask

   // Checks the combinational request path and records the tag when a handshake is expected.
   task automatic check_req(input string tag, input logic exp_req, input logic [NB-1:0] exp_gnt,
                            input int exp_id);
      check({tag, " per_req"}, 64'(bus.per_req_o), 64'(exp_req));
      check({tag, " core_gnt"}, 64'(bus.core_gnt_o), 64'(exp_gnt));
      if (exp_req) begin
         check({tag, " per_id"}, 64'(bus.per_id_o), 64'(exp_id));
         check({tag, " per_add"}, 64'(bus.per_add_o), 64'(addr_of(exp_id)));
         check({tag, " per_wen"}, 64'(bus.per_wen_o), 64'(wen_pat[exp_id]));
         check({tag, " per_wdata"}, 64'(bus.per_wdata_o), 64'(wdata_of(exp_id)));
         check({tag, " per_be"}, 64'(bus.per_be_o), 64'(be_of(exp_id)));
      end
      if (exp_gnt != '0) sb_q.push_back(core_idx_t'(exp_id));
   endtask

   function automatic void sb_remove(input core_idx_t id);
      for (int i = 0; i < sb_q.size(); i++) begin
         if (sb_q[i] == id) begin
            sb_q.delete(i);
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL sb_remove: tag %0d not outstanding, required present", id);
   endfunction

   // Pops the oldest in-flight tag and answers it with random data.
   task automatic respond(input string tag);
      core_idx_t     id;
      logic [DW-1:0] d;
      logic          o;
      id = sb_q.pop_front();
      d  = $urandom;
      o  = 1'($urandom_range(0, 1));
      bus.per_r_valid_i = 1'b1;
      bus.per_r_id_i    = IDW'(id);
      bus.per_r_rdata_i = d;
      bus.per_r_opc_i   = o;
      settle();
      check({tag, " r_valid"}, 64'(bus.core_r_valid_o), 64'(4'b0001 << id));
      check({tag, " r_rdata"}, 64'(bus.core_r_rdata_o), 64'(d));
      check({tag, " r_opc"}, 64'(bus.core_r_opc_o), 64'(o));
      tick();
      bus.per_r_valid_i = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (sb_q.size() > 0) respond(tag);
   endtask

   initial begin
      wen_pat = 4'b0101;
      for (int k = 0; k < 8; k++) begin
         tbl[k] = '{req: 4'b1111, gnt: 1'b1, exp_req: 1'b1,
                    exp_gnt: 4'(1 << (k % 4)), exp_id: core_idx_t'(k % 4)};
      end
      tbl[8] = '{req: 4'b1111, gnt: 1'b1, exp_req: 1'b0, exp_gnt: 4'b0000, exp_id: core_idx_t'(0)};

      for (int i = 0; i < NB; i++) begin
         bus.core_add_i[i*AW +: AW]   = addr_of(i);
         bus.core_wdata_i[i*DW +: DW] = wdata_of(i);
         bus.core_be_i[i*BW +: BW]    = be_of(i);
      end
      bus.core_wen_i    = wen_pat;
      bus.per_r_id_i    = '0;
      bus.per_r_rdata_i = 32'h1234_5678;
      bus.per_r_opc_i   = 1'b1;

      // Reset with live traffic on every input: all outputs must be held low.
      rst               = 1'b1;
      bus.core_req_i    = 4'b1111;
      bus.per_gnt_i     = 1'b1;
      bus.per_r_valid_i = 1'b1;
      settle();
      check("rst per_req", 64'(bus.per_req_o), 64'd0);
      check("rst core_gnt", 64'(bus.core_gnt_o), 64'd0);
      check("rst r_valid", 64'(bus.core_r_valid_o), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      idle();
      settle();
      check("post-rst busy", 64'(busy), 64'd0);
      check("post-rst err", 64'(err), 64'd0);
      check("post-rst per_req", 64'(bus.per_req_o), 64'd0);

      // Round-robin sweep, wrap, then every core capped at MAX_OUTST.
      for (int k = 0; k < 9; k++) begin
         bus.core_req_i = tbl[k].req;
         bus.per_gnt_i  = tbl[k].gnt;
         settle();
         check_req($sformatf("t1 row%0d", k), tbl[k].exp_req, tbl[k].exp_gnt, int'(tbl[k].exp_id));
         tick();
      end
      idle();
      settle();
      check("t1 busy outstanding", 64'(busy), 64'd1);
      drain("t1 rsp");
      settle();
      check("t1 busy drained", 64'(busy), 64'd0);

      // Lock: core 2 held through three refused cycles although core 0 joins with rr at 0.
      bus.core_req_i = 4'b0100;
      settle(); check_req("t2 wait0", 1'b1, 4'b0000, 2); tick();
      bus.core_req_i = 4'b0101;
      settle(); check_req("t2 wait1", 1'b1, 4'b0000, 2); tick();
      settle(); check_req("t2 wait2", 1'b1, 4'b0000, 2); tick();
      bus.per_gnt_i = 1'b1;
      settle(); check_req("t2 grant2", 1'b1, 4'b0100, 2); tick();
      bus.core_req_i = 4'b0001;
      settle(); check_req("t2 grant0", 1'b1, 4'b0001, 0); tick();
      idle();
      drain("t2 rsp");

      // Cap: core 1 fills up, core 3 is served past it, a response frees core 1 again.
      bus.per_gnt_i  = 1'b1;
      bus.core_req_i = 4'b0010;
      settle(); check_req("t3 c1 a", 1'b1, 4'b0010, 1); tick();
      settle(); check_req("t3 c1 b", 1'b1, 4'b0010, 1); tick();
      bus.core_req_i = 4'b1010;
      settle(); check_req("t3 skip", 1'b1, 4'b1000, 3); tick();
      bus.core_req_i    = 4'b0010;
      bus.per_r_valid_i = 1'b1;
      bus.per_r_id_i    = IDW'(1);
      settle();
      check_req("t3 capped", 1'b0, 4'b0000, 0);
      check("t3 capped r_valid", 64'(bus.core_r_valid_o), 64'(4'b0010));
      sb_remove(core_idx_t'(1));
      tick();
      bus.per_r_valid_i = 1'b0;
      settle(); check_req("t3 regrant", 1'b1, 4'b0010, 1); tick();
      idle();
      drain("t3 rsp");

      // Handshake and response for core 0 in the same cycle leave its count at 1.
      bus.per_gnt_i  = 1'b1;
      bus.core_req_i = 4'b0001;
      settle(); check_req("t4 first", 1'b1, 4'b0001, 0); tick();
      bus.per_r_valid_i = 1'b1;
      bus.per_r_id_i    = IDW'(0);
      bus.per_r_rdata_i = 32'hDEAD_BEEF;
      bus.per_r_opc_i   = 1'b0;
      settle();
      check_req("t4 same", 1'b1, 4'b0001, 0);
      check("t4 same r_valid", 64'(bus.core_r_valid_o), 64'(4'b0001));
      check("t4 same rdata", 64'(bus.core_r_rdata_o), 64'h0000_0000_DEAD_BEEF);
      sb_remove(core_idx_t'(0));
      tick();
      bus.per_r_valid_i = 1'b0;
      settle(); check_req("t4 room", 1'b1, 4'b0001, 0); tick();
      settle(); check_req("t4 full", 1'b0, 4'b0000, 0); tick();
      idle();
      drain("t4 rsp");
      settle();
      check("t4 busy drained", 64'(busy), 64'd0);

      // Response for a core with nothing in flight: dropped, err sets next cycle and sticks.
      bus.per_r_valid_i = 1'b1;
      bus.per_r_id_i    = IDW'(2);
      settle();
      check("t5 cnt0 r_valid", 64'(bus.core_r_valid_o), 64'd0);
      check("t5 cnt0 err before", 64'(err), 64'd0);
      tick();
      bus.per_r_valid_i = 1'b0;
      settle();
      check("t5 cnt0 err set", 64'(err), 64'd1);
      tick();
      settle();
      check("t5 cnt0 err sticky", 64'(err), 64'd1);

      // Build cnt = {1,0,2,0} with core 3 locked, then reset mid-flight.
      bus.per_gnt_i  = 1'b1;
      bus.core_req_i = 4'b0101;
      settle(); check_req("t6 load a", 1'b1, 4'b0100, 2); tick();
      settle(); check_req("t6 load b", 1'b1, 4'b0001, 0); tick();
      bus.core_req_i = 4'b0100;
      settle(); check_req("t6 load c", 1'b1, 4'b0100, 2); tick();
      bus.core_req_i = 4'b1000;
      bus.per_gnt_i  = 1'b0;
      settle(); check_req("t6 lock", 1'b1, 4'b0000, 3); tick();
      rst               = 1'b1;
      bus.per_gnt_i     = 1'b1;
      bus.per_r_valid_i = 1'b1;
      bus.per_r_id_i    = IDW'(0);
      settle();
      check("t6 rst per_req", 64'(bus.per_req_o), 64'd0);
      check("t6 rst core_gnt", 64'(bus.core_gnt_o), 64'd0);
      check("t6 rst r_valid", 64'(bus.core_r_valid_o), 64'd0);
      check("t6 rst per_id", 64'(bus.per_id_o), 64'd0);
      check("t6 rst rdata", 64'(bus.core_r_rdata_o), 64'd0);
      check("t6 rst busy", 64'(busy), 64'd0);
      check("t6 rst err", 64'(err), 64'd0);
      tick();
      rst = 1'b0;
      idle();
      sb_q.delete();
      settle();
      check("t6 after busy", 64'(busy), 64'd0);
      check("t6 after err", 64'(err), 64'd0);
      check("t6 after per_req", 64'(bus.per_req_o), 64'd0);
      bus.core_req_i = 4'b1001;
      settle(); check_req("t6 rr0 nolock", 1'b1, 4'b0000, 0); tick();
      bus.per_gnt_i = 1'b1;
      settle(); check_req("t6 grant", 1'b1, 4'b0001, 0); tick();
      idle();

      // Out-of-range id: dropped and flagged.
      bus.per_r_valid_i = 1'b1;
      bus.per_r_id_i    = IDW'(5);
      settle();
      check("t5 id5 r_valid", 64'(bus.core_r_valid_o), 64'd0);
      check("t5 id5 err before", 64'(err), 64'd0);
      tick();
      bus.per_r_valid_i = 1'b0;
      settle();
      check("t5 id5 err set", 64'(err), 64'd1);
      drain("t6 rsp");
      settle();
      check("final err sticky", 64'(err), 64'd1);
      check("final busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
